// File: rtl/fmul_share_arbiter_if.sv
// Handshake and data bus between the requesters, the shared float multiplier
// and the arbiter that sits between them.
interface fmul_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TAG_W   = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic                      mul_valid;
  logic                      mul_ready;
  logic [DATA_W-1:0]         mul_data;
  logic                      mul_rsp_valid;
  logic                      mul_rsp_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [TAG_W-1:0]          rsp_tag;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  // Requesters plus multiplier: everything outside the arbiter.
  modport master (
    output req_valid, req_data, req_tag, mul_ready, mul_rsp_valid, rsp_ready,
    input  req_ready, mul_valid, mul_data, mul_rsp_ready, rsp_valid, rsp_tag,
           rsp_id, busy
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, req_tag, mul_ready, mul_rsp_valid, rsp_ready,
    output req_ready, mul_valid, mul_data, mul_rsp_ready, rsp_valid, rsp_tag,
           rsp_id, busy
  );
endinterface

// File: rtl/fmul_share_arbiter.sv
// Round-robin sharing of one iterative float multiplier among NUM_REQ
// requesters; ownership is held until the owner accepts its result.
module fmul_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  fmul_share_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    owner;
  logic [TAG_W-1:0]   tag_q;

  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand_id;
  logic [ID_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               rsp_fire;
  logic               can_issue;
  logic               issue_fire;
  int unsigned        cand;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand    = (32'(rr_ptr) + k) % NUM_REQ;
      cand_id = ID_W'(cand);
      if (!found && bus.req_valid[cand_id]) begin
        found     = 1'b1;
        grant_idx = cand_id;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  assign rsp_fire   = bus.mul_rsp_valid && bus.mul_rsp_ready && (state == WAIT_RSP);
  // Reset gating keeps the request side quiet while reset is held.
  assign can_issue  = !flush && !reset && ((state == IDLE) || rsp_fire);
  assign issue_fire = bus.mul_valid && bus.mul_ready;

  assign bus.mul_valid     = can_issue && found;
  assign bus.mul_data      = bus.req_data[grant_idx*DATA_W +: DATA_W];
  assign bus.req_ready     = grant & {NUM_REQ{can_issue && bus.mul_ready}};
  assign bus.mul_rsp_ready = (state == IDLE) ? 1'b1 : bus.rsp_ready[owner];
  assign bus.rsp_tag       = tag_q;
  assign bus.rsp_id        = owner;
  assign bus.busy          = (state == WAIT_RSP);

  always_comb begin
    bus.rsp_valid        = '0;
    bus.rsp_valid[owner] = bus.mul_rsp_valid && (state == WAIT_RSP) && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      tag_q  <= '0;
    end else if (flush) begin
      state <= IDLE;
      owner <= '0;
      tag_q <= '0;
    end else if (issue_fire) begin
      // Covers both a fresh issue from IDLE and a back-to-back handover.
      state  <= WAIT_RSP;
      owner  <= grant_idx;
      tag_q  <= bus.req_tag[grant_idx*TAG_W +: TAG_W];
      rr_ptr <= next_ptr;
    end else if (rsp_fire) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed bench for fmul_share_arbiter; the bench plays both the requesters
// and the multiplier.
module tb_fmul_share_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned TAG_W   = 4;

  localparam logic [DATA_W-1:0] D0 = 128'h3FF0_0000_0000_0001_4000_0000_0000_0002;
  // Zero times infinity: a special-case bundle with a one-cycle result.
  localparam logic [DATA_W-1:0] D1 = 128'h0000_0000_0000_0000_7FF0_0000_0000_0000;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fmul_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  fmul_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    cyc();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.mul_rsp_valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data = {D1, D0};
    bus.req_tag = '0;
    bus.mul_ready = 1'b1;
    bus.mul_rsp_valid = 1'b1;
    bus.rsp_ready = 2'b11;
    cyc();
    #1;
    tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
    tests++; if (bus.mul_valid !== 1'b0) begin fails++; $display("FAIL reset_mul_valid got %b want 0", bus.mul_valid); end
    tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid); end
    tests++; if (bus.rsp_tag !== 4'h0) begin fails++; $display("FAIL reset_rsp_tag got %h want 0", bus.rsp_tag); end
    tests++; if (bus.rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    cyc();
    bus.req_valid = '0;
    bus.mul_rsp_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    cyc();
    bus.req_valid = 2'b01;
    bus.req_tag = {4'h0, 4'h3};
    bus.rsp_ready = 2'b00;
    #1;
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_req_ready got %b want 01", bus.req_ready); end
    tests++; if (bus.mul_valid !== 1'b1) begin fails++; $display("FAIL single_mul_valid got %b want 1", bus.mul_valid); end
    tests++; if (bus.mul_data !== D0) begin fails++; $display("FAIL single_mul_data got %h want %h", bus.mul_data, D0); end
    cyc();
    bus.req_valid = 2'b00;
    #1;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", bus.busy); end
    repeat (3) cyc();
    #1;
    tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL single_rsp_early got %b want 00", bus.rsp_valid); end
    cyc();
    bus.mul_rsp_valid = 1'b1;
    bus.rsp_ready = 2'b01;
    #1;
    tests++; if (bus.rsp_valid !== 2'b01) begin fails++; $display("FAIL single_rsp_valid got %b want 01", bus.rsp_valid); end
    tests++; if (bus.rsp_tag !== 4'h3) begin fails++; $display("FAIL single_rsp_tag got %h want 3", bus.rsp_tag); end
    tests++; if (bus.rsp_id !== 1'b0) begin fails++; $display("FAIL single_rsp_id got %b want 0", bus.rsp_id); end
    tests++; if (bus.mul_rsp_ready !== 1'b1) begin fails++; $display("FAIL single_mul_rsp_ready got %b want 1", bus.mul_rsp_ready); end
    cyc();
    bus.mul_rsp_valid = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_contention();
    logic [1:0] ev;
    logic [1:0] er;
    logic [3:0] et;
    apply_reset();
    bus.req_tag = {4'h5, 4'hA};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1;
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL cont_first_grant got %b want 01", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.mul_rsp_valid = 1'b1;
      if (i == 3) bus.req_valid = 2'b00;
      #1;
      ev = (i % 2 == 0) ? 2'b01 : 2'b10;
      et = (i % 2 == 0) ? 4'hA : 4'h5;
      er = (i == 3) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
      tests++; if (bus.rsp_valid !== ev) begin fails++; $display("FAIL cont_rsp_valid[%0d] got %b want %b", i, bus.rsp_valid, ev); end
      tests++; if (bus.rsp_tag !== et) begin fails++; $display("FAIL cont_rsp_tag[%0d] got %h want %h", i, bus.rsp_tag, et); end
      tests++; if (bus.req_ready !== er) begin fails++; $display("FAIL cont_req_ready[%0d] got %b want %b", i, bus.req_ready, er); end
    end
    cyc();
    bus.mul_rsp_valid = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL cont_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_back_pressure();
    cyc();
    bus.req_valid = 2'b10;
    bus.req_tag = {4'h9, 4'h2};
    bus.rsp_ready = 2'b00;
    #1;
    tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL bp_issue got %b want 10", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b01;
    bus.mul_rsp_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cyc();
      #1;
      tests++; if (bus.mul_rsp_ready !== 1'b0) begin fails++; $display("FAIL bp_mul_rsp_ready[%0d] got %b want 0", j, bus.mul_rsp_ready); end
      tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL bp_req_ready[%0d] got %b want 00", j, bus.req_ready); end
      tests++; if (bus.rsp_valid !== 2'b10) begin fails++; $display("FAIL bp_rsp_valid[%0d] got %b want 10", j, bus.rsp_valid); end
    end
    cyc();
    bus.rsp_ready = 2'b10;
    #1;
    tests++; if (bus.mul_rsp_ready !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b want 1", bus.mul_rsp_ready); end
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL bp_release_grant got %b want 01", bus.req_ready); end
    tests++; if (bus.rsp_tag !== 4'h9) begin fails++; $display("FAIL bp_rsp_tag got %h want 9", bus.rsp_tag); end
    cyc();
    bus.req_valid = 2'b00;
    bus.mul_rsp_valid = 1'b0;
    bus.rsp_ready = 2'b01;
    #1;
    tests++; if (bus.rsp_id !== 1'b0) begin fails++; $display("FAIL bp_new_owner got %b want 0", bus.rsp_id); end
    tests++; if (bus.rsp_tag !== 4'h2) begin fails++; $display("FAIL bp_new_tag got %h want 2", bus.rsp_tag); end
    cyc();
    bus.mul_rsp_valid = 1'b1;
    #1;
    tests++; if (bus.rsp_valid !== 2'b01) begin fails++; $display("FAIL bp_second_rsp got %b want 01", bus.rsp_valid); end
    cyc();
    bus.mul_rsp_valid = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL bp_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_special();
    cyc();
    bus.req_valid = 2'b10;
    bus.req_tag = {4'hE, 4'h1};
    #1;
    tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL spec_grant got %b want 10", bus.req_ready); end
    tests++; if (bus.mul_data !== D1) begin fails++; $display("FAIL spec_mul_data got %h want %h", bus.mul_data, D1); end
    cyc();
    bus.req_valid = 2'b00;
    bus.mul_rsp_valid = 1'b1;
    bus.rsp_ready = 2'b11;
    #1;
    tests++; if (bus.rsp_valid !== 2'b10) begin fails++; $display("FAIL spec_rsp_valid got %b want 10", bus.rsp_valid); end
    tests++; if (bus.rsp_tag !== 4'hE) begin fails++; $display("FAIL spec_rsp_tag got %h want e", bus.rsp_tag); end
    tests++; if (bus.rsp_id !== 1'b1) begin fails++; $display("FAIL spec_rsp_id got %b want 1", bus.rsp_id); end
    cyc();
    bus.mul_rsp_valid = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL spec_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_flush();
    cyc();
    bus.req_valid = 2'b01;
    bus.req_tag = {4'h6, 4'hC};
    #1;
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL flush_issue got %b want 01", bus.req_ready); end
    cyc();
    #1;
    tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL flush_pending got %b want 00", bus.req_ready); end
    cyc();
    flush = 1'b1;
    bus.mul_rsp_valid = 1'b1;
    #1;
    tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL flush_rsp_valid got %b want 00", bus.rsp_valid); end
    tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL flush_req_ready got %b want 00", bus.req_ready); end
    tests++; if (bus.mul_valid !== 1'b0) begin fails++; $display("FAIL flush_mul_valid got %b want 0", bus.mul_valid); end
    cyc();
    flush = 1'b0;
    bus.mul_rsp_valid = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    tests++; if (bus.rsp_tag !== 4'h0) begin fails++; $display("FAIL flush_tag got %h want 0", bus.rsp_tag); end
    tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL flush_rr_kept got %b want 10", bus.req_ready); end
    cyc();
    bus.mul_rsp_valid = 1'b1;
    bus.req_valid = 2'b01;
    #1;
    tests++; if (bus.rsp_valid !== 2'b10) begin fails++; $display("FAIL flush_after_rsp got %b want 10", bus.rsp_valid); end
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL flush_req0_issue got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    #1;
    tests++; if (bus.rsp_valid !== 2'b01) begin fails++; $display("FAIL flush_req0_rsp got %b want 01", bus.rsp_valid); end
    cyc();
    bus.mul_rsp_valid = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    cyc();
    bus.req_valid = 2'b01;
    bus.req_tag = {4'h4, 4'hB};
    #1;
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL arst_issue got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    bus.mul_rsp_valid = 1'b1;
    bus.rsp_ready = 2'b00;
    #1;
    tests++; if (bus.rsp_valid !== 2'b01) begin fails++; $display("FAIL arst_pre_rsp got %b want 01", bus.rsp_valid); end
    #2;
    reset = 1'b1;
    #1;
    tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL arst_rsp_valid got %b want 00", bus.rsp_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    tests++; if (bus.rsp_tag !== 4'h0) begin fails++; $display("FAIL arst_tag got %h want 0", bus.rsp_tag); end
    tests++; if (bus.mul_valid !== 1'b0) begin fails++; $display("FAIL arst_mul_valid got %b want 0", bus.mul_valid); end
    cyc();
    reset = 1'b0;
    bus.mul_rsp_valid = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1;
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL arst_rr_zero got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    bus.mul_rsp_valid = 1'b1;
    cyc();
    bus.mul_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_special();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fmul_share_arbiter.md
Name: fmul_share_arbiter

Overview:
- Shares the single iterative float multiplier among NUM_REQ requesters, e.g. the FMUL issue path and the FMADD sequencer.
- Arbitrates round-robin and forwards the winner's operand bundle (op, rm, unpacked a/b) to the multiplier.
- Locks ownership until the multiplier's result handshake completes.
- Steers the response handshake and the requester's tag back to the owner. Result fields (man/exp/sgn/round/sticky/IV/rm) go from the multiplier straight to a shared result bus.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 128, width of one flattened operand bundle forwarded to the multiplier
TAG_W, 4, per-request tag width returned with the response

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
flush  in  1  synchronous pipeline flush, forwarded to the multiplier
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accepted
req_data  in  NUM_REQ*DATA_W  operand bundles; requester i at [i*DATA_W +: DATA_W]
req_tag  in  NUM_REQ*TAG_W  tags; requester i at [i*TAG_W +: TAG_W]
mul_valid  out  1  to multiplier valid_in
mul_ready  in  1  from multiplier ready_out
mul_data  out  DATA_W  selected operand bundle
mul_rsp_valid  in  1  from multiplier valid_out
mul_rsp_ready  out  1  to multiplier ready_in
rsp_valid  out  NUM_REQ  result valid, one-hot to owner
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_tag  out  TAG_W  tag of the owning request
rsp_id  out  $clog2(NUM_REQ)  index of owner
busy  out  1  operation in flight (state == WAIT_RSP)

Behaviour:
- State machine states:
  - IDLE: no owner.
  - WAIT_RSP: one op issued; owner, tag and id are registered.
- Reset values: state IDLE, rr_ptr 0, owner 0, tag register 0, busy 0. Outputs during reset: rsp_valid 0, rsp_tag 0, rsp_id 0, req_ready 0, mul_valid 0.
- can_issue = !flush && (state==IDLE || rsp_fire), where rsp_fire = mul_rsp_valid && mul_rsp_ready && state==WAIT_RSP.
- Grant: first asserted req_valid found by scanning upward from rr_ptr with wrap-around; this gives a one-hot grant.
  - mul_valid = can_issue && |req_valid.
  - mul_data = bundle of the granted requester.
  - req_ready = grant & {NUM_REQ{can_issue && mul_ready}}.
- Issue fire (mul_valid && mul_ready):
  - Register owner = granted index, tag = its req_tag.
  - rr_ptr <= (owner+1) mod NUM_REQ.
  - Go to WAIT_RSP.
- mul_rsp_ready = (state==IDLE) ? 1 : rsp_ready[owner]. Driving 1 in IDLE keeps the multiplier issue-capable, since its ready_out requires ready_in.
- rsp_valid[i] = mul_rsp_valid && state==WAIT_RSP && owner==i && !flush. rsp_tag and rsp_id come from the registers.
- On rsp_fire with no issue that cycle: go to IDLE.
- On rsp_fire with a new issue in the same cycle (back-to-back): stay in WAIT_RSP with the new owner. No bubble.
- Owner holds rsp_ready low: stay in WAIT_RSP, multiplier result held, no new issue. Other requesters stall; no starvation beyond the owner's stall.
- mul_rsp_valid in IDLE (spurious): ignored, no rsp_valid.
- Fast paths: special-case operands (NaN/inf/zero) return valid one cycle after issue; regular operands take 5 cycles. The arbiter is latency-agnostic and adds zero cycles to either path.
- Flush:
  - flush=1 forces req_ready=0, mul_valid=0, rsp_valid=0.
  - Next edge: state IDLE, owner 0, tag 0. rr_ptr is unchanged.
- Reset mid-operation: same as flush but asynchronous, and rr_ptr goes to 0.
- A request that is valid but not granted must stay stable until accepted. The arbiter does not latch request data.

Test Plan:
- Single op: reset, req_valid=01, tag 0x3, multiplier accepts.
  - Issue-cycle: req_ready=01, mul_valid=1.
  - busy=1 until mul_rsp_valid; then rsp_valid=01, rsp_tag=0x3, rsp_id=0.
  - IDLE the cycle after rsp_ready.
- Contention: req_valid=11 held continuously with rsp_ready=11 → issue order 0,1,0,1.
  - Each new issue coincides with the previous rsp_fire (no idle cycle between).
  - rsp_tag alternates with each owner's tag.
- Back-pressure: owner 1 holds rsp_ready[1]=0 for 4 cycles while req_valid[0]=1.
  - mul_rsp_ready=0, req_ready=00, rsp_valid=10 stable.
  - Request 0 is issued the cycle rsp_ready[1] rises.
- Special-case op (zero × inf, 1-cycle multiplier result) from requester 1 → rsp_valid=10 one cycle after issue, rsp_tag correct.
- Flush during WAIT_RSP (cycle 2 of 5) with req_valid=01 pending.
  - Flush cycle: rsp_valid=0, req_ready=0.
  - Next cycle: IDLE, busy=0, rr_ptr unchanged.
  - Request 0 issues the following cycle.
- Async reset asserted mid-op → all outputs 0 immediately, rr_ptr=0; after release, requester 0 wins when req_valid=11.
